// File: rtl/ddr3_dma_pkg.sv
// Shared types and constants for the DDR3 DMA read path.
// Optional feature macro (used by ddr3_dma_read): DDR3_DMA_RD_ERR_EN.
package ddr3_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;
    localparam int         BURST_LSB  = 3;

endpackage

// File: rtl/ddr3_dma_read_if.sv
// Bundle of the MIG app read-command/return signals, the request/done
// handshake and the dout stream. master = DMA engine, slave = environment.
interface ddr3_dma_read_if
    import ddr3_dma_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int LEN_W  = 27
);
    logic                          init_calib_complete;
    logic [LEN_W+BURST_LSB-1:0]    app_addr;
    logic [2:0]                    app_cmd;
    logic                          app_en;
    logic                          app_rdy;
    logic [DATA_W-1:0]             app_rd_data;
    logic                          app_rd_data_valid;
    logic                          app_rd_data_end;
    logic                          read_req;
    logic [LEN_W-1:0]              read_start_addr;
    logic [LEN_W-1:0]              read_length;
    logic                          read_done;
    logic                          dout_rdy;
    logic                          dout_en;
    logic [DATA_W-1:0]             dout;
    logic                          dout_eop;

    modport master (
        input  init_calib_complete, app_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, read_req, read_start_addr, read_length, dout_rdy,
        output app_addr, app_cmd, app_en, read_done, dout_en, dout, dout_eop
    );

    modport slave (
        output init_calib_complete, app_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, read_req, read_start_addr, read_length, dout_rdy,
        input  app_addr, app_cmd, app_en, read_done, dout_en, dout, dout_eop
    );
endinterface

// File: rtl/ddr3_dma_rd_fifo.sv
// Synchronous first-word-fall-through FIFO for returned read beats.
// The head is held in a register loaded from the array at the next read
// pointer, with a bypass when that same slot is being written this cycle.
module ddr3_dma_rd_fifo #(
    parameter int DATA_W  = 512,
    parameter int FIFO_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  din,
    input  logic               rd_en,
    output logic [DATA_W-1:0]  dout,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);
    localparam int              DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_ONE  = 1;
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_next;
    logic [FIFO_AW:0]   count_reg;
    logic [DATA_W-1:0]  head_reg;
    logic               do_wr;
    logic               do_rd;

    assign empty       = (count_reg == '0);
    assign count       = count_reg;
    assign dout        = head_reg;
    assign do_rd       = rd_en & ~empty;
    assign do_wr       = wr_en & (count_reg != CNT_FULL);
    assign rd_ptr_next = do_rd ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

    // Storage array write port (no reset so it maps onto RAM).
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Registered head read: always shows the entry at the read pointer.
    always_ff @(posedge clk) begin
        if (do_wr && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= din;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            unique case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/ddr3_dma_read.sv
// Read-side DMA engine for the MIG DDR3 app interface. Issues a run of
// burst read commands, buffers returns in a credit-protected FIFO and
// streams them out with an end-of-packet marker.
// Optional feature macro: DDR3_DMA_RD_ERR_EN adds a sticky rd_err output.
module ddr3_dma_read
    import ddr3_dma_pkg::*;
#(
    parameter int DATA_W  = 512,
    parameter int LEN_W   = 27,
    parameter int FIFO_AW = 5
) (
    input  logic            clk,
    input  logic            rst,
    ddr3_dma_read_if.master bus
`ifdef DDR3_DMA_RD_ERR_EN
    ,
    output logic            rd_err
`endif
);
    localparam logic [FIFO_AW:0] CREDIT_MAX = (FIFO_AW+1)'(1 << FIFO_AW);
    localparam logic [FIFO_AW:0] CNT_ONE    = 1;
    localparam logic [LEN_W-1:0] LEN_ONE    = 1;

    state_t             state_reg;
    logic [LEN_W-1:0]   cmd_addr_reg;
    logic [LEN_W-1:0]   cmd_left_reg;
    logic [LEN_W-1:0]   beat_left_reg;
    logic [FIFO_AW:0]   outstanding_reg;

    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_dout;
    logic [FIFO_AW:0]   credit;
    logic               app_en_int;
    logic               cmd_accept;
    logic               pop;
    logic               fifo_wr;
    logic               unused_rd_end;

    // Every beat is a complete BL8 burst, so the end marker carries no information.
    assign unused_rd_end = bus.app_rd_data_end;

    // Free FIFO slots not yet promised to an issued command.
    assign credit     = CREDIT_MAX - (fifo_count + outstanding_reg);
    assign app_en_int = (state_reg == CMD) & bus.init_calib_complete & (credit != '0);
    assign cmd_accept = app_en_int & bus.app_rdy;
    assign pop        = ~fifo_empty & bus.dout_rdy;
    // Returns with nothing outstanding (late beats after a reset, or while idle) are dropped.
    assign fifo_wr    = bus.app_rd_data_valid & (state_reg != IDLE) & (outstanding_reg != '0);

    assign bus.app_en    = app_en_int;
    assign bus.app_addr  = {cmd_addr_reg, {BURST_LSB{1'b0}}};
    assign bus.app_cmd   = APP_CMD_RD;
    assign bus.read_done = (state_reg == DONE);
    assign bus.dout_en   = pop;
    assign bus.dout      = fifo_dout;
    assign bus.dout_eop  = pop & (beat_left_reg == LEN_ONE);

    ddr3_dma_rd_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (fifo_wr),
        .din   (bus.app_rd_data),
        .rd_en (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Transfer FSM with command address/length, beat and outstanding counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cmd_addr_reg    <= '0;
            cmd_left_reg    <= '0;
            beat_left_reg   <= '0;
            outstanding_reg <= '0;
        end else begin
            unique case ({cmd_accept, fifo_wr})
                2'b10:   outstanding_reg <= outstanding_reg + CNT_ONE;
                2'b01:   outstanding_reg <= outstanding_reg - CNT_ONE;
                default: outstanding_reg <= outstanding_reg;
            endcase

            if (pop) begin
                beat_left_reg <= beat_left_reg - LEN_ONE;
            end

            unique case (state_reg)
                IDLE: begin
                    if (bus.read_req) begin
                        cmd_addr_reg  <= bus.read_start_addr;
                        cmd_left_reg  <= bus.read_length;
                        beat_left_reg <= bus.read_length;
                        state_reg     <= (bus.read_length == '0) ? DONE : CMD;
                    end
                end
                CMD: begin
                    if (cmd_accept) begin
                        cmd_addr_reg <= cmd_addr_reg + LEN_ONE;
                        cmd_left_reg <= cmd_left_reg - LEN_ONE;
                        if (cmd_left_reg == LEN_ONE) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (beat_left_reg == LEN_ONE)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef DDR3_DMA_RD_ERR_EN
    // Sticky error: unexpected return, or a start accepted before calibration.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_err <= 1'b0;
        end else if ((bus.app_rd_data_valid && (outstanding_reg == '0)) ||
                     ((state_reg == IDLE) && bus.read_req && !bus.init_calib_complete)) begin
            rd_err <= 1'b1;
        end
    end
`endif
endmodule
